// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for a small MIPS subset.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// fetch unit's next-PC controls plus all datapath enables and mux selects.
module mc_ctrl #(
  parameter int unsigned CNT_W        = 32,
  parameter bit          ILLEGAL_HALT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction,
  input  logic [31:0]      zero,
  output logic [1:0]       nPC_sel,
  output logic             j_sel,
  output logic             pc_we,
  output logic             ir_we,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             alu_src,
  output logic [1:0]       ext_op,
  output logic [1:0]       alu_op,
  output logic             mem_we,
  output logic             illegal,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSubu  = 6'h23;
  localparam logic [5:0] FnJr    = 6'h08;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [5:0]       op_q, funct_q;
  logic [CNT_W-1:0] retired_q;

  logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_exec;
  logic [1:0] alu_op_e, ext_op_e;
  logic       alu_src_e;

  logic [1:0] npc_c, reg_dst_c, wd_sel_c, ext_op_c, alu_op_c;
  logic       j_sel_c, pc_we_c, ir_we_c, reg_we_c, alu_src_c, mem_we_c, illegal_c;

  // Branch resolution lives in the fetch unit, and only op/funct are decoded here.
  logic unused_inputs;
  assign unused_inputs = ^{zero, instruction[25:6]};

  // Decode the latched opcode into instruction classes and their ALU settings.
  always_comb begin
    is_addu   = (op_q == OpRtype) && (funct_q == FnAddu);
    is_subu   = (op_q == OpRtype) && (funct_q == FnSubu);
    is_jr     = (op_q == OpRtype) && (funct_q == FnJr);
    is_ori    = (op_q == OpOri);
    is_lui    = (op_q == OpLui);
    is_lw     = (op_q == OpLw);
    is_sw     = (op_q == OpSw);
    is_beq    = (op_q == OpBeq);
    is_j      = (op_q == OpJ);
    is_jal    = (op_q == OpJal);
    is_exec   = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq;
    alu_op_e  = 2'b00;
    alu_src_e = 1'b0;
    ext_op_e  = 2'b00;
    if (is_subu || is_beq) begin
      alu_op_e = 2'b01;
    end else if (is_ori) begin
      alu_op_e  = 2'b10;
      alu_src_e = 1'b1;
    end else if (is_lui) begin
      alu_op_e  = 2'b10;
      alu_src_e = 1'b1;
      ext_op_e  = 2'b10;
    end else if (is_lw || is_sw) begin
      alu_src_e = 1'b1;
      ext_op_e  = 2'b01;
    end
  end

  // Next-state and per-state control outputs; every control is 0 unless set below.
  always_comb begin
    state_d   = state_q;
    npc_c     = 2'b00;
    j_sel_c   = 1'b0;
    pc_we_c   = 1'b0;
    ir_we_c   = 1'b0;
    reg_we_c  = 1'b0;
    reg_dst_c = 2'b00;
    wd_sel_c  = 2'b00;
    alu_src_c = 1'b0;
    ext_op_c  = 2'b00;
    alu_op_c  = 2'b00;
    mem_we_c  = 1'b0;
    illegal_c = 1'b0;
    unique case (state_q)
      StFetch: begin
        ir_we_c = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        if (is_j) begin
          pc_we_c = 1'b1;
          j_sel_c = 1'b1;
          state_d = StFetch;
        end else if (is_jal) begin
          pc_we_c   = 1'b1;
          j_sel_c   = 1'b1;
          reg_we_c  = 1'b1;
          reg_dst_c = 2'b10;
          wd_sel_c  = 2'b10;
          state_d   = StFetch;
        end else if (is_jr) begin
          pc_we_c = 1'b1;
          npc_c   = 2'b11;
          state_d = StFetch;
        end else if (is_exec) begin
          state_d = StExec;
        end else begin
          illegal_c = 1'b1;
          if (ILLEGAL_HALT) begin
            state_d = StHalt;
          end else begin
            pc_we_c = 1'b1;
            state_d = StFetch;
          end
        end
      end
      StExec: begin
        alu_op_c  = alu_op_e;
        alu_src_c = alu_src_e;
        ext_op_c  = ext_op_e;
        if (is_beq) begin
          pc_we_c = 1'b1;
          npc_c   = 2'b10;
          state_d = StFetch;
        end else if (is_lw || is_sw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        alu_op_c  = alu_op_e;
        alu_src_c = alu_src_e;
        ext_op_c  = ext_op_e;
        if (is_sw) begin
          mem_we_c = 1'b1;
          pc_we_c  = 1'b1;
          state_d  = StFetch;
        end else begin
          state_d = StWb;
        end
      end
      StWb: begin
        alu_op_c  = alu_op_e;
        alu_src_c = alu_src_e;
        ext_op_c  = ext_op_e;
        reg_we_c  = 1'b1;
        pc_we_c   = 1'b1;
        reg_dst_c = (is_addu || is_subu) ? 2'b01 : 2'b00;
        wd_sel_c  = is_lw ? 2'b01 : 2'b00;
        state_d   = StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // State register, opcode/funct latch and retired-instruction counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFetch;
      op_q      <= 6'd0;
      funct_q   <= 6'd0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (ir_we_c) begin
        op_q    <= instruction[31:26];
        funct_q <= instruction[5:0];
      end
      if (pc_we_c) begin
        retired_q <= retired_q + CntOne;
      end
    end
  end

  // Reset forces every output low, even the FETCH-state ir_we.
  always_comb begin
    nPC_sel = rst ? npc_c     : 2'b00;
    j_sel   = rst & j_sel_c;
    pc_we   = rst & pc_we_c;
    ir_we   = rst & ir_we_c;
    reg_we  = rst & reg_we_c;
    reg_dst = rst ? reg_dst_c : 2'b00;
    wd_sel  = rst ? wd_sel_c  : 2'b00;
    alu_src = rst & alu_src_c;
    ext_op  = rst ? ext_op_c  : 2'b00;
    alu_op  = rst ? alu_op_c  : 2'b00;
    mem_we  = rst & mem_we_c;
    illegal = rst & illegal_c;
    state_o = rst ? state_q   : 3'd0;
    retired = rst ? retired_q : '0;
  end

endmodule
